// File: rtl/queue_pop_adapter_if.sv
// Bundle of queue-side, downstream-side and status signals for queue_pop_adapter.
// The adapter itself connects through the slave modport; whatever drives the
// queue flags, flush and downstream ready connects through the master modport.
interface queue_pop_adapter_if #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
);

  // Queue side
  logic                  q_empty_IN;
  logic [DATA_WIDTH-1:0] q_data_IN;
  logic                  q_popReq_OUT;

  // Control
  logic                  flush_IN;

  // Downstream side
  logic                  out_valid_OUT;
  logic [DATA_WIDTH-1:0] out_data_OUT;
  logic                  out_ready_IN;

  // Status
  logic [1:0]            occ_OUT;
  logic [CNT_WIDTH-1:0]  popCount_OUT;

  modport slave (
    input  q_empty_IN,
    input  q_data_IN,
    output q_popReq_OUT,
    input  flush_IN,
    output out_valid_OUT,
    output out_data_OUT,
    input  out_ready_IN,
    output occ_OUT,
    output popCount_OUT
  );

  modport master (
    output q_empty_IN,
    output q_data_IN,
    input  q_popReq_OUT,
    output flush_IN,
    input  out_valid_OUT,
    input  out_data_OUT,
    output out_ready_IN,
    input  occ_OUT,
    input  popCount_OUT
  );

endinterface

// File: rtl/queue_pop_adapter.sv
// Pops entries from a combinational-read queue into a 2-entry skid buffer and
// presents them on a valid/ready output. slot0 is the head shown downstream,
// slot1 catches the entry popped while the head is stalled. Also counts every
// pop issued since reset.
module queue_pop_adapter #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input logic                clk,
  input logic                reset,
  queue_pop_adapter_if.slave bus
);

  // Occupancy-coded states: the state value is also the entry count.
  localparam logic [1:0] S0 = 2'd0;
  localparam logic [1:0] S1 = 2'd1;
  localparam logic [1:0] S2 = 2'd2;

  logic [1:0]            state_q,    state_d;
  logic [DATA_WIDTH-1:0] slot0_q,    slot0_d;
  logic [DATA_WIDTH-1:0] slot1_q,    slot1_d;
  logic [CNT_WIDTH-1:0]  popCount_q, popCount_d;

  logic popReq;
  logic outValid;
  logic xfer;

  // Pop only with room in the buffer, data in the queue, out of reset and not
  // flushing; the queue advances on the same edge that captures its head.
  always_comb begin
    popReq = reset && !bus.flush_IN && !bus.q_empty_IN && (state_q != S2);
  end

  // Output is valid whenever something is buffered, except during a flush
  // cycle, so nothing is handed downstream while the buffer is being dropped.
  always_comb begin
    outValid = (state_q != S0) && !bus.flush_IN;
    xfer     = outValid && bus.out_ready_IN;
  end

  // Next-state and slot update: flush wins, otherwise pop/xfer per occupancy.
  always_comb begin
    state_d = state_q;
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    if (bus.flush_IN) begin
      state_d = S0;
    end else begin
      case (state_q)
        S0: begin
          if (popReq) begin
            state_d = S1;
            slot0_d = bus.q_data_IN;
          end
        end
        S1: begin
          if (popReq && xfer) begin
            state_d = S1;
            slot0_d = bus.q_data_IN;
          end else if (popReq) begin
            state_d = S2;
            slot1_d = bus.q_data_IN;
          end else if (xfer) begin
            state_d = S0;
          end
        end
        S2: begin
          if (xfer) begin
            state_d = S1;
            slot0_d = slot1_q;
          end
        end
        default: begin
          state_d = S0;
        end
      endcase
    end
  end

  // Pop counter wraps naturally at its width and is untouched by flush.
  always_comb begin
    popCount_d = popCount_q + {{(CNT_WIDTH-1){1'b0}}, popReq};
  end

  // State, slots and counter registers; synchronous active-low reset clears all.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= S0;
      slot0_q    <= '0;
      slot1_q    <= '0;
      popCount_q <= '0;
    end else begin
      state_q    <= state_d;
      slot0_q    <= slot0_d;
      slot1_q    <= slot1_d;
      popCount_q <= popCount_d;
    end
  end

  // Drive the bundle outputs.
  always_comb begin
    bus.q_popReq_OUT  = popReq;
    bus.out_valid_OUT = outValid;
    bus.out_data_OUT  = slot0_q;
    bus.occ_OUT       = state_q;
    bus.popCount_OUT  = popCount_q;
  end

endmodule

// File: tb/tb_queue_pop_adapter.sv
// Self-checking bench for queue_pop_adapter: a modelled queue feeds the DUT,
// popped entries go to a scoreboard and are checked when handed downstream.
module tb_queue_pop_adapter;

  localparam int DW = 8;
  localparam int CW = 4;

  logic clk;
  logic reset;

  queue_pop_adapter_if #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) bus ();

  queue_pop_adapter #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic [DW-1:0] qMem[$];
  logic [DW-1:0] expQ[$];
  logic [DW-1:0] seen[$];
  logic [CW-1:0] cntModel;
  int checks;
  int errors;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", tag, actual, expected);
    end
  endtask

  // Drive one cycle of inputs just after a falling edge, check outputs against
  // the model, then advance through the rising edge and update the model.
  task automatic applyStimulus(input logic rstN, input logic flush, input logic ready, input logic forceEmpty);
    logic emptyNow;
    logic expPop;
    logic expValid;
    logic dutPop;
    emptyNow          = forceEmpty || (qMem.size() == 0);
    reset             = rstN;
    bus.flush_IN      = flush;
    bus.out_ready_IN  = ready;
    bus.q_empty_IN    = emptyNow;
    bus.q_data_IN     = (qMem.size() != 0) ? qMem[0] : '0;
    #1;
    expPop   = rstN && !flush && !emptyNow && (expQ.size() < 2);
    expValid = (expQ.size() != 0) && !flush;
    dutPop   = bus.q_popReq_OUT;
    checkOutput("popReq",   {31'd0, bus.q_popReq_OUT},  {31'd0, expPop});
    checkOutput("outValid", {31'd0, bus.out_valid_OUT}, {31'd0, expValid});
    checkOutput("occ",      {30'd0, bus.occ_OUT},       expQ.size());
    checkOutput("popCount", {28'd0, bus.popCount_OUT},  {28'd0, cntModel});
    if (expValid) checkOutput("outData", {24'd0, bus.out_data_OUT}, {24'd0, expQ[0]});
    @(posedge clk);
    if (!rstN) begin
      expQ.delete();
      cntModel = '0;
    end else if (flush) begin
      expQ.delete();
    end else begin
      if (expValid && ready) seen.push_back(expQ.pop_front());
      if (expPop) begin
        expQ.push_back(qMem[0]);
        cntModel = cntModel + 1'b1;
      end
    end
    if (dutPop && qMem.size() != 0) void'(qMem.pop_front());
    @(negedge clk);
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    cntModel = '0;
    reset            = 1'b0;
    bus.flush_IN     = 1'b0;
    bus.out_ready_IN = 1'b0;
    bus.q_empty_IN   = 1'b1;
    bus.q_data_IN    = '0;
    @(negedge clk);

    // Reset, then idle with empty queue
    for (int i = 0; i < 2; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    checkOutput("rstData", {24'd0, bus.out_data_OUT}, 32'h0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);

    // Streaming 0x01..0x04 with ready high
    for (int i = 1; i <= 4; i++) qMem.push_back(DW'(i));
    seen.delete();
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    checkOutput("streamCnt", {28'd0, bus.popCount_OUT}, 32'd4);
    checkOutput("streamLen", seen.size(), 32'd4);
    for (int i = 0; i < seen.size(); i++) checkOutput("streamSeq", {24'd0, seen[i]}, i + 1);

    // Backpressure with 0x10..0x13
    for (int i = 0; i < 4; i++) qMem.push_back(DW'(8'h10 + i));
    seen.delete();
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    #1;
    checkOutput("bpOcc",  {30'd0, bus.occ_OUT}, 32'd2);
    checkOutput("bpData", {24'd0, bus.out_data_OUT}, 32'h10);
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    checkOutput("bpLen", seen.size(), 32'd4);
    for (int i = 0; i < seen.size(); i++) checkOutput("bpSeq", {24'd0, seen[i]}, 32'h10 + i);

    // Empty queue for 10 cycles: counter must not move
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
    checkOutput("emptyCnt", {28'd0, bus.popCount_OUT}, 32'd8);

    // Flush while holding two entries
    for (int i = 0; i < 6; i++) qMem.push_back(DW'(8'h20 + i));
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
    #1;
    checkOutput("flushOcc", {30'd0, bus.occ_OUT}, 32'd0);
    seen.delete();
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    checkOutput("flushNext", {24'd0, seen[0]}, 32'h22);

    // Reset mid-stream while holding two entries
    for (int i = 0; i < 4; i++) qMem.push_back(DW'(8'h30 + i));
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    #1;
    checkOutput("midRstData", {24'd0, bus.out_data_OUT}, 32'h0);
    checkOutput("midRstCnt",  {28'd0, bus.popCount_OUT}, 32'd0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);

    // Counter wrap: 17 pops from reset on a 4-bit counter
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    qMem.delete();
    for (int i = 0; i < 17; i++) qMem.push_back(DW'(8'h40 + i));
    for (int i = 0; i < 20; i++) applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    checkOutput("wrapCnt", {28'd0, bus.popCount_OUT}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/queue_pop_adapter.md
QUEUE_POP_ADAPTER -- requirements
Module: queue_pop_adapter

Interface
REQ-001 The block SHALL be clocked by clk and reset by reset, which is synchronous and active-low (clock clk).
REQ-002 Parameter DATA_WIDTH, default 8: width of queue entries and of the output data.
REQ-003 Parameter CNT_WIDTH, default 16: width of the pop counter.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 reset  input  1  synchronous active-low reset.
REQ-006 q_empty_IN  input  1  queue empty flag.
REQ-007 q_data_IN  input  DATA_WIDTH  queue head data; valid in the same cycle, combinational read.
REQ-008 q_popReq_OUT  output  1  pop request to the queue; the queue advances its head on the next rising edge.
REQ-009 flush_IN  input  1  discards all buffered entries.
REQ-010 out_valid_OUT  output  1  out_data_OUT holds a valid entry.
REQ-011 out_data_OUT  output  DATA_WIDTH  oldest buffered entry.
REQ-012 out_ready_IN  input  1  downstream accepts the entry.
REQ-013 occ_OUT  output  2  buffered entry count, 0..2.
REQ-014 popCount_OUT  output  CNT_WIDTH  total pops issued since reset.

Function
REQ-015 The block SHALL hold a 2-entry buffer: slot0 (head, drives out_data_OUT) and slot1 (skid).
REQ-016 The state SHALL be exactly one of S0 (occ=0), S1 (occ=1) or S2 (occ=2), and occ_OUT SHALL equal the occupancy.
REQ-017 q_popReq_OUT SHALL be combinational and equal to: reset high, flush_IN low, q_empty_IN low, and state not S2.
REQ-018 A pop SHALL capture q_data_IN at the same edge at which the queue advances; there is no extra read latency.
REQ-019 out_valid_OUT SHALL be (state != S0) and flush_IN low.
REQ-020 A transfer (xfer) SHALL occur when out_valid_OUT is high and out_ready_IN is high in the same cycle.
REQ-021 Pop without xfer: S0->S1 (slot0<=q_data_IN); S1->S2 (slot1<=q_data_IN).
REQ-022 Xfer without pop: S1->S0; S2->S1 (slot0<=slot1).
REQ-023 Pop with xfer in S1: stay in S1, slot0<=q_data_IN.
REQ-024 Pop with xfer in S2 cannot occur, because no pop is issued in S2.
REQ-025 Neither pop nor xfer: state and slots SHALL hold.
REQ-026 Pop-to-output latency SHALL be 1 cycle, i.e. out_valid_OUT rises the cycle after the first pop; sustained throughput SHALL be 1 entry/cycle while out_ready_IN stays high.
REQ-027 out_data_OUT SHALL stay stable while out_valid_OUT is high and out_ready_IN is low.
REQ-028 Flush: on the next edge the state SHALL become S0; no pop and no xfer occur in the flush cycle.
REQ-029 Slot contents SHALL NOT be cleared by flush; they are don't-care in S0.
REQ-030 Flush SHALL take priority over all pop and xfer activity, and popCount_OUT SHALL NOT be cleared by flush.
REQ-031 popCount_OUT SHALL increment by 1 on every edge where q_popReq_OUT is high, and SHALL wrap modulo 2^CNT_WIDTH.
REQ-032 The block SHALL never pop while q_empty_IN is high, and SHALL never hold more than 2 entries.

Reset
REQ-033 While reset is low at an edge: state<=S0, slot0<=0, slot1<=0, popCount_OUT<=0.
REQ-034 While reset is low, q_popReq_OUT SHALL be low combinationally.
REQ-035 After reset the outputs SHALL be: out_valid_OUT=0, out_data_OUT=0, occ_OUT=0, popCount_OUT=0, q_popReq_OUT=0.
REQ-036 Reset asserted mid-operation SHALL discard buffered data; it takes priority over flush, pop and xfer.

Verification
REQ-037 Streaming: queue preloaded with 0x01..0x04, out_ready_IN=1 -> out_data_OUT shows 0x01,0x02,0x03,0x04 on 4 consecutive cycles starting one cycle after the first pop; popCount_OUT=4.
REQ-038 Backpressure: queue holds 0x10..0x13, out_ready_IN=0 for 5 cycles -> occ_OUT=2, q_popReq_OUT=0, out_data_OUT=0x10 stable; after out_ready_IN=1 the outputs are 0x10,0x11,0x12,0x13 in order with no loss.
REQ-039 Empty queue: q_empty_IN=1 for 10 cycles -> q_popReq_OUT=0 throughout, out_valid_OUT=0, popCount_OUT unchanged.
REQ-040 Flush in S2: occ_OUT=2, assert flush_IN for 1 cycle -> out_valid_OUT=0 in that cycle, occ_OUT=0 on the next cycle, and the following entry popped is the next queue entry.
REQ-041 Counter wrap: with CNT_WIDTH=4, 17 pops -> popCount_OUT=1.
REQ-042 Reset mid-stream: reset low for 1 cycle while occ_OUT=2 -> all outputs return to their REQ-035 values at the next edge, and q_popReq_OUT=0 during the reset cycle.
